// File: rtl/simd_acc_bank_if.sv
// simd_acc_bank_if: bundles the write, read and clear signals of simd_acc_bank.
//   master modport: the client that issues requests (drives wr_*, rd_en/rd_addr, clr_start).
//   slave modport : the accumulator bank (drives rd_data, rd_valid, busy, sat_flag).
interface simd_acc_bank_if #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LANE_WIDTH = 16
);
  localparam int unsigned LANES = DATA_WIDTH / LANE_WIDTH;

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [1:0]            wr_op;
  logic [LANES-1:0]      wr_lmask;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  clr_start;
  logic                  busy;
  logic                  sat_flag;

  modport master (
    output wr_en, wr_addr, wr_data, wr_op, wr_lmask, rd_en, rd_addr, clr_start,
    input  rd_data, rd_valid, busy, sat_flag
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_op, wr_lmask, rd_en, rd_addr, clr_start,
    output rd_data, rd_valid, busy, sat_flag
  );
endinterface

// File: rtl/simd_acc_bank.sv
// simd_acc_bank: SIMD read-modify-write accumulator bank with per-lane mask, 2-bit op code
// (overwrite / add / subtract / lane clear) and a hardware clear sweep.
//
// Ports:
//   clk    - single clock, rising edge
//   rst    - synchronous active-high reset (RAM contents are kept)
//   bus_io - simd_acc_bank_if.slave: write RMW request, read request/response, clear control
//
// Optional feature: define ACC_SATURATE_EN for signed saturating add/sub lanes and a live
// sat_flag; without it lanes wrap modulo 2**LANE_WIDTH and sat_flag is tied low.
//
// Pipeline: stage A (accept edge) reads the old word, stage B computes and commits one edge
// later. A stage-A hit on the stage-B address takes the stage-B result instead of the RAM.
// Reads are read-first with two register stages after the RAM read (latency 2).
module simd_acc_bank #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned LANE_WIDTH = 16
) (
  input logic           clk,
  input logic           rst,
  simd_acc_bank_if.slave bus_io
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned LANES = DATA_WIDTH / LANE_WIDTH;

  localparam logic [1:0] OpWrite = 2'b00;
  localparam logic [1:0] OpAdd   = 2'b01;
  localparam logic [1:0] OpSub   = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;

  typedef enum logic {StIdle, StClear} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  clr_we, last_clr, wr_acc;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  b_valid_q;
  logic [ADDR_WIDTH-1:0] b_addr_q;
  logic [DATA_WIDTH-1:0] b_data_q, b_old_q, b_result, old_d;
  logic [1:0]            b_op_q;
  logic [LANES-1:0]      b_mask_q;

  logic [LANE_WIDTH-1:0] old_l, dat_l, res_l;

  logic [DATA_WIDTH-1:0] rd_raw_q, rd_pipe_q, rd_data_q;
  logic                  rd_v0_q, rd_v1_q, rd_valid_q;

`ifdef ACC_SATURATE_EN
  logic [LANE_WIDTH:0]   wide_l;
  logic [LANES-1:0]      lane_sat;
  logic                  sat_q;
`endif

  // Clear sweep FSM
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.clr_start) begin
          state_d   = StClear;
          clr_cnt_d = '0;
        end
      end
      StClear: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == '1) begin
          state_d   = StIdle;
          clr_cnt_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign clr_we   = (state_q == StClear);
  assign last_clr = clr_we && (clr_cnt_q == '1);
  // The edge that writes the last swept address already accepts a new op; clr_start beats wr_en.
  assign wr_acc   = bus_io.wr_en && (((state_q == StIdle) && !bus_io.clr_start) || last_clr);

  // Stage B lane-wise compute
  always_comb begin
    b_result = b_old_q;
    old_l    = '0;
    dat_l    = '0;
    res_l    = '0;
`ifdef ACC_SATURATE_EN
    wide_l   = '0;
    lane_sat = '0;
`endif
    for (int unsigned l = 0; l < LANES; l++) begin
      old_l = b_old_q[l*LANE_WIDTH +: LANE_WIDTH];
      dat_l = b_data_q[l*LANE_WIDTH +: LANE_WIDTH];
      unique case (b_op_q)
        OpWrite: res_l = dat_l;
        OpAdd:   res_l = old_l + dat_l;
        OpSub:   res_l = old_l - dat_l;
        OpClear: res_l = '0;
        default: res_l = old_l;
      endcase
`ifdef ACC_SATURATE_EN
      // Sign-extend by one bit; a mismatch of the top two bits means signed overflow.
      if (b_op_q == OpAdd) begin
        wide_l = {old_l[LANE_WIDTH-1], old_l} + {dat_l[LANE_WIDTH-1], dat_l};
      end else begin
        wide_l = {old_l[LANE_WIDTH-1], old_l} - {dat_l[LANE_WIDTH-1], dat_l};
      end
      if (((b_op_q == OpAdd) || (b_op_q == OpSub)) &&
          (wide_l[LANE_WIDTH] != wide_l[LANE_WIDTH-1])) begin
        res_l       = wide_l[LANE_WIDTH] ? {1'b1, {(LANE_WIDTH-1){1'b0}}}
                                         : {1'b0, {(LANE_WIDTH-1){1'b1}}};
        lane_sat[l] = b_mask_q[l];
      end
`endif
      if (b_mask_q[l]) begin
        b_result[l*LANE_WIDTH +: LANE_WIDTH] = res_l;
      end
    end
  end

  // Stage A old-value select: in-flight result first, then a same-edge clear write, then RAM.
  always_comb begin
    old_d = mem_q[bus_io.wr_addr];
    if (clr_we && (clr_cnt_q == bus_io.wr_addr)) begin
      old_d = '0;
    end
    if (b_valid_q && (b_addr_q == bus_io.wr_addr)) begin
      old_d = b_result;
    end
  end

  // Control state with reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      clr_cnt_q  <= '0;
      b_valid_q  <= 1'b0;
      rd_v0_q    <= 1'b0;
      rd_v1_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
`ifdef ACC_SATURATE_EN
      sat_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      b_valid_q  <= wr_acc;
      rd_v0_q    <= bus_io.rd_en;
      rd_v1_q    <= rd_v0_q;
      rd_valid_q <= rd_v1_q;
      rd_data_q  <= rd_pipe_q;
`ifdef ACC_SATURATE_EN
      sat_q      <= b_valid_q && (|lane_sat);
`endif
    end
  end

  // Datapath registers, no reset needed
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      b_addr_q <= bus_io.wr_addr;
      b_data_q <= bus_io.wr_data;
      b_op_q   <= bus_io.wr_op;
      b_mask_q <= bus_io.wr_lmask;
      b_old_q  <= old_d;
    end
    rd_raw_q  <= mem_q[bus_io.rd_addr];
    rd_pipe_q <= rd_raw_q;
  end

  // RAM: a reset edge squashes both the stage-B commit and the sweep write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (b_valid_q) begin
        mem_q[b_addr_q] <= b_result;
      end else if (clr_we) begin
        mem_q[clr_cnt_q] <= '0;
      end
    end
  end

  assign bus_io.rd_data  = rd_data_q;
  assign bus_io.rd_valid = rd_valid_q;
  assign bus_io.busy     = clr_we;
`ifdef ACC_SATURATE_EN
  assign bus_io.sat_flag = sat_q;
`else
  assign bus_io.sat_flag = 1'b0;
`endif

endmodule

// File: tb/tb_simd_acc_bank.sv
// tb_simd_acc_bank: directed and randomized checks of simd_acc_bank against a lane-wise
// arithmetic reference model (model_mem holds the expected contents of every word).
module tb_simd_acc_bank;

  localparam int unsigned AW    = 9;
  localparam int unsigned DW    = 64;
  localparam int unsigned LW    = 16;
  localparam int unsigned DEPTH = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  simd_acc_bank_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANE_WIDTH(LW)) bus ();

  simd_acc_bank #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LANE_WIDTH(LW)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  int n_checks = 0;
  int n_err    = 0;
  logic [DW-1:0] model_mem [DEPTH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: per-lane plain integer arithmetic.
  function automatic logic [DW-1:0] ref_op(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                            input logic [1:0] op, input logic [3:0] m,
                                            output bit sat);
    logic [DW-1:0] r;
    logic [LW-1:0] ol, dl;
    int            o, x, v;
    r   = old;
    sat = 1'b0;
    for (int l = 0; l < 4; l++) begin
      ol = old[l*LW +: LW];
      dl = d[l*LW +: LW];
`ifdef ACC_SATURATE_EN
      o = int'(signed'(ol));
      x = int'(signed'(dl));
`else
      o = int'(ol);
      x = int'(dl);
`endif
      case (op)
        2'b00:   v = x;
        2'b01:   v = o + x;
        2'b10:   v = o - x;
        default: v = 0;
      endcase
`ifdef ACC_SATURATE_EN
      if (op == 2'b01 || op == 2'b10) begin
        if (v > 32767)  begin v = 32767;  if (m[l]) sat = 1'b1; end
        if (v < -32768) begin v = -32768; if (m[l]) sat = 1'b1; end
      end
`else
      v = (v + 65536) % 65536;
`endif
      if (m[l]) r[l*LW +: LW] = v[LW-1:0];
    end
    return r;
  endfunction

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] op,
                    input logic [3:0] m);
    bit s;
    bus.wr_en    = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    bus.wr_op    = op;
    bus.wr_lmask = m;
    cycle();
    bus.wr_en    = 1'b0;
    model_mem[a] = ref_op(model_mem[a], d, op, m, s);
  endtask

  // Idle edge first so any just-accepted write has committed before the read edge.
  task automatic rd_chk(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
    cycle();
    bus.rd_en   = 1'b1;
    bus.rd_addr = a;
    cycle();
    bus.rd_en   = 1'b0;
    cycle();
    chk({tag, "_valid_early"}, bus.rd_valid, 1'b0);
    cycle();
    chk({tag, "_valid"}, bus.rd_valid, 1'b1);
    chk(tag, bus.rd_data, exp);
  endtask

  task automatic sweep(input logic [AW-1:0] drop_addr, output int busy_cycles);
    bus.clr_start = 1'b1;
    cycle();
    bus.clr_start = 1'b0;
    busy_cycles = 0;
    while (bus.busy === 1'b1 && busy_cycles < int'(DEPTH) + 8) begin
      // A mid-sweep write after its address was swept must be dropped.
      if (busy_cycles == 100) begin
        bus.wr_en    = 1'b1;
        bus.wr_addr  = drop_addr;
        bus.wr_data  = 64'hDEAD_BEEF_CAFE_F00D;
        bus.wr_op    = 2'b00;
        bus.wr_lmask = 4'hF;
      end else begin
        bus.wr_en = 1'b0;
      end
      cycle();
      busy_cycles++;
    end
    bus.wr_en = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) model_mem[i] = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int            bc;
    bit            s;
    logic [AW-1:0] a;
    logic [DW-1:0] d, v40;

    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_op = '0; bus.wr_lmask = '0;
    bus.rd_en = 1'b0; bus.rd_addr = '0; bus.clr_start = 1'b0;
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_rd_valid", bus.rd_valid, 1'b0);
    chk("rst_rd_data", bus.rd_data, 64'h0);
    chk("rst_sat", bus.sat_flag, 1'b0);

    // Zero the whole bank so the model starts known.
    sweep(9'd20, bc);
    chk("sweep0_busy_len", bc, DEPTH);

    // Overwrite then add
    wr(9'h10, 64'd100, 2'b00, 4'hF);
    wr(9'h10, 64'd50, 2'b01, 4'hF);
    rd_chk(9'h10, 64'd150, "ow_add");

    // Back-to-back adds on one address
    wr(9'h50, 64'd0, 2'b00, 4'hF);
    for (int i = 0; i < 4; i++) wr(9'h50, {4{16'd10}}, 2'b01, 4'hF);
    rd_chk(9'h50, {4{16'd40}}, "b2b_add");

    // Interleaved A,B,A
    wr(9'h60, 64'd100, 2'b00, 4'hF);
    wr(9'h61, 64'd200, 2'b00, 4'hF);
    wr(9'h60, 64'd10, 2'b01, 4'hF);
    wr(9'h61, 64'd20, 2'b01, 4'hF);
    wr(9'h60, 64'd5, 2'b01, 4'hF);
    rd_chk(9'h60, 64'd115, "aba_a");
    rd_chk(9'h61, 64'd220, "aba_b");

    // Subtract from zero
    wr(9'h70, {4{16'd1}}, 2'b10, 4'hF);
    rd_chk(9'h70, {4{16'hFFFF}}, "sub_zero");

`ifdef ACC_SATURATE_EN
    wr(9'h71, {4{16'h7FFF}}, 2'b00, 4'hF);
    wr(9'h71, {4{16'd1}}, 2'b01, 4'hF);
    chk("sat_before", bus.sat_flag, 1'b0);
    cycle();
    chk("sat_pulse", bus.sat_flag, 1'b1);
    cycle();
    chk("sat_after", bus.sat_flag, 1'b0);
    rd_chk(9'h71, {4{16'h7FFF}}, "sat_clamp");
`else
    wr(9'h71, {4{16'hFFFF}}, 2'b00, 4'hF);
    wr(9'h71, {4{16'd2}}, 2'b01, 4'hF);
    cycle();
    chk("sat_tied_low", bus.sat_flag, 1'b0);
    rd_chk(9'h71, {4{16'd1}}, "add_wrap");
`endif

    // Lane mask and lane clear
    wr(9'h80, 64'h1111_2222_3333_4444, 2'b00, 4'hF);
    wr(9'h80, {4{16'hAAAA}}, 2'b00, 4'b0101);
    rd_chk(9'h80, 64'h1111_AAAA_3333_AAAA, "mask_ow");
    wr(9'h80, 64'h0, 2'b11, 4'b1000);
    rd_chk(9'h80, 64'h0000_AAAA_3333_AAAA, "lane_clr");

    // Read and write to the same address on one edge: read sees the old word.
    bus.rd_en = 1'b1; bus.rd_addr = 9'h10;
    wr(9'h10, 64'd7, 2'b00, 4'hF);
    bus.rd_en = 1'b0;
    cycle();
    cycle();
    chk("rw_same_valid", bus.rd_valid, 1'b1);
    chk("rw_same_old", bus.rd_data, 64'd150);
    rd_chk(9'h10, 64'd7, "rw_same_new");

    // Random back-to-back ops over a small address window to exercise forwarding.
    for (int i = 0; i < 300; i++) begin
      a = 9'h100 + 9'($urandom_range(0, 7));
      d = {$urandom, $urandom};
      wr(a, d, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
    end
    for (int i = 0; i < 8; i++) begin
      a = 9'h100 + 9'(i);
      rd_chk(a, model_mem[a], "rand_rmw");
    end

    // Fill then full clear with a dropped mid-sweep write
    wr(9'd0, {$urandom, $urandom}, 2'b00, 4'hF);
    wr(9'(DEPTH / 2), {$urandom, $urandom}, 2'b00, 4'hF);
    wr(9'(DEPTH - 1), {$urandom, $urandom}, 2'b00, 4'hF);
    cycle();
    sweep(9'd20, bc);
    chk("sweep_busy_len", bc, DEPTH);
    rd_chk(9'd0, 64'h0, "clr_lo");
    rd_chk(9'(DEPTH / 2), 64'h0, "clr_mid");
    rd_chk(9'(DEPTH - 1), 64'h0, "clr_hi");
    rd_chk(9'd20, 64'h0, "clr_drop");

    // Reset mid-sweep: swept addresses zero, unswept ones untouched
    wr(9'd2, {$urandom, $urandom} | 64'h1, 2'b00, 4'hF);
    wr(9'd400, {$urandom, $urandom} | 64'h1, 2'b00, 4'hF);
    cycle();
    bus.clr_start = 1'b1;
    cycle();
    bus.clr_start = 1'b0;
    for (int i = 0; i < 100; i++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst_busy", bus.busy, 1'b0);
    model_mem[2] = '0;
    rd_chk(9'd2, model_mem[2], "midrst_swept");
    rd_chk(9'd400, model_mem[400], "midrst_unswept");

    // Reset on the edge after a write acceptance squashes it
    wr(9'd40, 64'h0123_4567_89AB_CDEF, 2'b00, 4'hF);
    cycle();
    v40 = model_mem[40];
    bus.wr_en = 1'b1; bus.wr_addr = 9'd40; bus.wr_data = 64'hFFFF_0000_FFFF_0000;
    bus.wr_op = 2'b00; bus.wr_lmask = 4'hF;
    cycle();
    bus.wr_en = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("sqrst_busy", bus.busy, 1'b0);
    chk("sqrst_rd_valid", bus.rd_valid, 1'b0);
    rd_chk(9'd40, v40, "sqrst_squashed");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/simd_acc_bank.md
# simd_acc_bank

Parametrised SIMD read-modify-write accumulator. It extends the fixed 16-bit-lane overwrite/accumulate memory with a configurable lane width, a 2-bit op code (overwrite, add, subtract, lane clear) and a per-lane write mask. It also adds a hardware clear sweep, so the bank can be zeroed without a software scrub loop. It sits between the polynomial-multiply datapath and the result readout, holding partial sums per address.

## Interface
- ADDR_WIDTH, 9, address bits; DEPTH = 2**ADDR_WIDTH words
- DATA_WIDTH, 64, word width; must be a multiple of LANE_WIDTH
- LANE_WIDTH, 16, SIMD lane width; LANES = DATA_WIDTH/LANE_WIDTH
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write/RMW request, sampled at rising edge when busy=0
- wr_addr  in  ADDR_WIDTH  target word
- wr_data  in  DATA_WIDTH  operand
- wr_op  in  2  00 overwrite, 01 add, 10 subtract (old − wr_data), 11 lane clear
- wr_lmask  in  LANES  1 = lane updated, 0 = lane keeps old value
- rd_en  in  1  read request
- rd_addr  in  ADDR_WIDTH  read address
- rd_data  out  DATA_WIDTH  registered read data
- rd_valid  out  1  one-cycle pulse, rd_data valid
- clr_start  in  1  pulse: zero the whole bank
- busy  out  1  clear sweep in progress
- sat_flag  out  1  per-op saturation indicator (only with ACC_SATURATE_EN)

## Operation
- Pipeline stage A, edge T: accept wr_en and issue the RAM read of wr_addr.
- Stage B, cycle T..T+1: compute the new word lane-wise and write it to RAM at edge T+1.
- Throughput is one op per cycle.
- Forwarding: if the stage-A address equals the stage-B address, the old value comes from the stage-B result register, not the RAM. Back-to-back ops to one address must equal sequential execution.
- Lane arithmetic, default build: add/sub modulo 2**LANE_WIDTH, with no carry between lanes.
- Overwrite: lane = wr_data lane. Lane clear: lane = 0.
- Masked-off lanes pass old through for every op.
- Clear FSM states are IDLE and CLEAR.
  - IDLE → CLEAR on clr_start, or on rst deassertion? No. Entry to CLEAR is only on clr_start sampled in IDLE.
  - In CLEAR, a counter writes 0 to addresses 0..DEPTH−1, one per cycle.
  - After address DEPTH−1 is written, the FSM returns to IDLE.
- clr_start in CLEAR is ignored.
- clr_start and wr_en on the same edge: clr_start wins and the write is dropped.
- wr_en while busy=1 is dropped silently.
- A stage-B commit due on the clr_start edge still completes.
- Reads are allowed during CLEAR. They return the pre- or post-clear value for each address depending on sweep position.
- rst: FSM → IDLE, counter → 0, stage-B op squashed (not committed), busy=0, rd_valid=0, rd_data=0, sat_flag=0.
- RAM contents are not affected by rst. A reset mid-sweep leaves the bank partially cleared.

## Timing
- Write accepted at edge T is committed at edge T+1.
- Read sampled at edge T:
  - RAM is read-first at edge T.
  - rd_data/rd_valid are registered at edge T+2, giving latency 2.
  - The read reflects writes accepted at or before edge T−2. Writes accepted at T−1 or T are not visible.
- Simultaneous read and write to the same address: the read returns the pre-write value.
- clr_start at edge T:
  - busy=1 after edge T.
  - Address k is written at edge T+1+k.
  - busy=0 after edge T+DEPTH.
  - wr_en is first accepted at edge T+DEPTH.
- rd_valid is never asserted except as the 2-cycle response to rd_en.

## Configuration
- ACC_SATURATE_EN defined:
  - Add/sub treat lanes as signed two's complement.
  - Results clamp to [−2**(LANE_WIDTH−1), 2**(LANE_WIDTH−1)−1].
  - sat_flag is high for the single cycle after edge T+1 when any unmasked lane of the op accepted at T clamped.
  - Forwarding uses the clamped value.
- ACC_SATURATE_EN undefined: modulo arithmetic as above, and sat_flag is tied to 0.

## Test plan
- Overwrite 100 to 0x10, then add 50 (mask all ones), then read 0x10 → 150, with rd_valid exactly 2 cycles after rd_en.
- Overwrite 0 to 0x50, then 4 consecutive-cycle adds of 10 to 0x50 → read 40. Interleave A,B,A adds (10,20,5) onto 100/200 → 115/220.
- Subtract 1 from a zeroed word → 0xFFFF per lane without macro. With ACC_SATURATE_EN, add 1 to 0x7FFF lanes → 0x7FFF and sat_flag pulses once.
- Mask 4'b0101 overwrite 0xAAAA… on word 0x1111_2222_3333_4444 → 0x1111_AAAA_3333_AAAA. Op 11 with mask 4'b1000 → top lane 0.
- Fill random data, pulse clr_start:
  - busy is high for exactly DEPTH cycles.
  - A wr_en during the sweep is dropped.
  - Reads of addresses 0, DEPTH/2 and DEPTH−1 return 0 afterwards.
- Assert rst mid-sweep and on the edge after a write acceptance:
  - busy=0 next cycle.
  - The squashed write is not visible.
  - Addresses already swept are 0 and unswept addresses are unchanged.
